// File: rtl/xbar_pkg.sv
// Shared crossbar types: source/destination index widths and the per-output lock state.
package xbar_pkg;

  localparam int XBAR_NUM_INPUT  = 4;
  localparam int XBAR_NUM_OUTPUT = 4;
  localparam int SRC_W           = $clog2(XBAR_NUM_INPUT);
  localparam int DST_W           = $clog2(XBAR_NUM_OUTPUT);

  typedef logic [SRC_W-1:0] src_idx_t;
  typedef logic [DST_W-1:0] dst_idx_t;

  typedef enum logic [0:0] {
    LOCK_IDLE   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_e;

  // Modular add used for round-robin scanning and pointer advance.
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority pick: first set request at or above the pointer, wrapping at N-1.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  logic [W-1:0] w_scan;

  // Scan from farthest to nearest so the candidate closest to the pointer is written last.
  always_comb begin
    w_scan  = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_scan  = W'(wrap_add(int'(i_ptr), k, N));
      o_idx   = i_req[w_scan] ? w_scan : o_idx;
      o_valid = o_valid | i_req[w_scan];
    end
    o_gnt = o_valid ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/xbar_arbiter.sv
// Per-output round-robin crossbar arbiter with zero-latency grants.
// Define XBAR_ARBITER_LOCK_EN to hold an output on one source until its last beat.
module xbar_arbiter
  import xbar_pkg::*;
#(
  parameter int NUM_INPUT  = XBAR_NUM_INPUT,
  parameter int NUM_OUTPUT = XBAR_NUM_OUTPUT,
  localparam int SW = $clog2(NUM_INPUT),
  localparam int DW = $clog2(NUM_OUTPUT)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_INPUT-1:0]                req_valid_i,
  input  logic [NUM_INPUT-1:0][DW-1:0]        req_dest_i,
  input  logic [NUM_INPUT-1:0]                req_last_i,
  output logic [NUM_INPUT-1:0]                req_ready_o,
  input  logic [NUM_OUTPUT-1:0]               out_ready_i,
  output logic [NUM_OUTPUT-1:0]               out_valid_o,
  output logic [NUM_OUTPUT-1:0][SW-1:0]       select_vector_o
);

  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] w_cand;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] w_req;
  logic [NUM_OUTPUT-1:0][NUM_INPUT-1:0] w_gnt;
  logic [NUM_OUTPUT-1:0][SW-1:0]        w_idx;
  logic [NUM_OUTPUT-1:0][SW-1:0]        r_ptr;
  logic [NUM_OUTPUT-1:0][SW-1:0]        r_last_sel;
  logic [NUM_OUTPUT-1:0]                w_valid;
  logic [NUM_OUTPUT-1:0]                w_hs;
  logic [NUM_OUTPUT-1:0]                w_adv;

  // Candidate matrix: source i competes for the output it addresses.
  always_comb begin
    w_cand = '0;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      for (int i = 0; i < NUM_INPUT; i++) begin
        w_cand[o][i] = req_valid_i[i] && (req_dest_i[i] == DW'(o));
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPUT; o++) begin : g_out
    rr_arbiter #(.N(NUM_INPUT)) u_rr (
      .i_req   (w_req[o]),
      .i_ptr   (r_ptr[o]),
      .o_gnt   (w_gnt[o]),
      .o_idx   (w_idx[o]),
      .o_valid (w_valid[o])
    );
  end

  assign out_valid_o = w_valid;
  assign w_hs        = w_valid & out_ready_i;

  // Select holds the previous winner when idle; ready folds in the output's back-pressure.
  always_comb begin
    select_vector_o = '0;
    req_ready_o     = '0;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      select_vector_o[o] = w_valid[o] ? w_idx[o] : r_last_sel[o];
      req_ready_o        = req_ready_o | (w_gnt[o] & {NUM_INPUT{out_ready_i[o]}});
    end
  end

`ifdef XBAR_ARBITER_LOCK_EN
  lock_state_e                   r_state     [NUM_OUTPUT];
  lock_state_e                   w_state_nxt [NUM_OUTPUT];
  logic [NUM_OUTPUT-1:0][SW-1:0] r_lock_src;
  logic [NUM_OUTPUT-1:0]         w_last;

  // Lock state register and the source captured on the first beat of a packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lock_src <= '0;
      for (int o = 0; o < NUM_OUTPUT; o++) r_state[o] <= LOCK_IDLE;
    end else begin
      for (int o = 0; o < NUM_OUTPUT; o++) begin
        r_state[o] <= w_state_nxt[o];
        if (r_state[o] == LOCK_IDLE && w_hs[o] && !w_last[o]) r_lock_src[o] <= w_idx[o];
      end
    end
  end

  // While locked, every other candidate is masked so a stalled or absent owner keeps the output.
  always_comb begin
    w_req = w_cand;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      case (r_state[o])
        LOCK_IDLE:   w_req[o] = w_cand[o];
        LOCK_LOCKED: w_req[o] = w_cand[o] & (NUM_INPUT'(1) << r_lock_src[o]);
        default:     w_req[o] = w_cand[o];
      endcase
    end
  end

  // Next lock state; the pointer only advances when a packet closes.
  always_comb begin
    w_last = '0;
    w_adv  = '0;
    for (int o = 0; o < NUM_OUTPUT; o++) begin
      w_state_nxt[o] = r_state[o];
      w_last[o]      = |(w_gnt[o] & req_last_i);
      w_adv[o]       = w_hs[o] && w_last[o];
      case (r_state[o])
        LOCK_IDLE:   w_state_nxt[o] = (w_hs[o] && !w_last[o]) ? LOCK_LOCKED : LOCK_IDLE;
        LOCK_LOCKED: w_state_nxt[o] = (w_hs[o] && w_last[o]) ? LOCK_IDLE : LOCK_LOCKED;
        default:     w_state_nxt[o] = LOCK_IDLE;
      endcase
    end
  end
`else
  logic w_unused_last;

  assign w_req         = w_cand;
  assign w_adv         = w_hs;
  assign w_unused_last = ^req_last_i;
`endif

  // Pointer and held select move only on a completed transfer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr      <= '0;
      r_last_sel <= '0;
    end else begin
      for (int o = 0; o < NUM_OUTPUT; o++) begin
        if (w_hs[o])  r_last_sel[o] <= w_idx[o];
        if (w_adv[o]) r_ptr[o]      <= SW'(wrap_add(int'(w_idx[o]), 1, NUM_INPUT));
      end
    end
  end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Self-checking bench for xbar_arbiter: directed cases plus a randomized scoreboard run.
module tb_xbar_arbiter;
  import xbar_pkg::*;

  localparam int NI = 4;
  localparam int NO = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NI-1:0]           req_valid;
  logic [NI-1:0][1:0]      req_dest;
  logic [NI-1:0]           req_last;
  logic [NI-1:0]           req_ready;
  logic [NO-1:0]           out_ready;
  logic [NO-1:0]           out_valid;
  logic [NO-1:0][1:0]      select_v;

  typedef struct packed {
    logic [NO-1:0]   ov;
    logic [2*NO-1:0] sel;
    logic [NI-1:0]   rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  int m_ptr [NO];
  int m_last[NO];
  int m_lsrc[NO];
  bit m_lock[NO];
  int m_win [NO];

  bit            pend   [NI];
  int            wcnt   [NI];
  int            hs_cnt [NO];
  int            acc_out[NO];
  logic [NI-1:0] rdy_s;
  logic [NI-1:0] pend_v;
  logic [NO-1:0] hs_s;
  int            exp_seq[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  xbar_arbiter #(.NUM_INPUT(NI), .NUM_OUTPUT(NO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_dest_i      (req_dest),
    .req_last_i      (req_last),
    .req_ready_o     (req_ready),
    .out_ready_i     (out_ready),
    .out_valid_o     (out_valid),
    .select_vector_o (select_v)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NO; o++) begin
      m_ptr[o]  = 0;
      m_last[o] = 0;
      m_lsrc[o] = 0;
      m_lock[o] = 1'b0;
    end
  endtask

  // Reference: pick the candidate with the smallest round-robin distance from the pointer.
  task automatic model_eval();
    exp_t e;
    e = '0;
    for (int o = 0; o < NO; o++) begin
      int best;
      int bd;
      best = -1;
      bd   = NI;
      for (int i = 0; i < NI; i++) begin
        bit cand;
        int d;
        cand = req_valid[i] && (int'(req_dest[i]) == o);
        if (m_lock[o] && i != m_lsrc[o]) cand = 1'b0;
        d = (i - m_ptr[o] + NI) % NI;
        if (cand && d < bd) begin
          bd   = d;
          best = i;
        end
      end
      m_win[o]          = best;
      e.ov[o]           = (best >= 0);
      e.sel[o*2 +: 2]   = (best >= 0) ? 2'(best) : 2'(m_last[o]);
      if (best >= 0 && out_ready[o]) e.rdy[best] = 1'b1;
    end
    sb_q.push_back(e);
  endtask

  task automatic model_step();
    for (int o = 0; o < NO; o++) begin
      if (m_win[o] >= 0 && out_ready[o]) begin
        int w;
        w         = m_win[o];
        m_last[o] = w;
`ifdef XBAR_ARBITER_LOCK_EN
        if (req_last[w]) begin
          m_lock[o] = 1'b0;
          m_ptr[o]  = (w + 1) % NI;
        end else begin
          m_lock[o] = 1'b1;
          m_lsrc[o] = w;
        end
`else
        m_ptr[o] = (w + 1) % NI;
`endif
      end
    end
  endtask

  // One clock: predict, compare against the scoreboard head, then advance the model with the DUT.
  task automatic cycle();
    exp_t e;
    #1;
    model_eval();
    e = sb_q.pop_front();
    check_eq("outputs", {out_valid, select_v, req_ready}, e);
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_dest  = '0;
    req_last  = '1;
    out_ready = '0;
    model_reset();
    @(negedge clk);
    cycle();
    cycle();

    // Reset state
    rst = 1'b0;
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_sel", select_v, 0);
    cycle();

    // Four sources on output 2: strict rotation 0,1,2,3,0
    req_valid = '1;
    for (int i = 0; i < NI; i++) req_dest[i] = 2'd2;
    out_ready = '1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("rr_sel", select_v[2], exp_seq[k]);
      check_eq("rr_rdy", req_ready, 64'(1) << exp_seq[k]);
      cycle();
    end

    // Concurrent grants on two outputs
    req_valid   = 4'b1010;
    req_dest[3] = 2'd0;
    req_dest[1] = 2'd1;
    #1;
    check_eq("par_valid", out_valid[1:0], 2'b11);
    check_eq("par_sel0", select_v[0], 3);
    check_eq("par_sel1", select_v[1], 1);
    check_eq("par_rdy", req_ready, 4'b1010);
    cycle();

    // Stalled output keeps its winner and pointer
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst         = 1'b0;
    req_valid   = 4'b0101;
    req_dest[0] = 2'd1;
    req_dest[2] = 2'd1;
    out_ready   = 4'b1101;
    repeat (5) begin
      #1;
      check_eq("stall_sel", select_v[1], 0);
      check_eq("stall_rdy", req_ready, 0);
      check_eq("stall_valid", out_valid[1], 1);
      cycle();
    end
    out_ready[1] = 1'b1;
    #1;
    check_eq("release_sel", select_v[1], 0);
    check_eq("release_rdy", req_ready, 4'b0001);
    cycle();
    #1;
    check_eq("next_sel", select_v[1], 2);
    check_eq("next_rdy", req_ready, 4'b0100);
    cycle();

    // Dropping a request re-arbitrates in the same cycle
    req_dest[0] = 2'd3;
    req_dest[2] = 2'd3;
    out_ready   = 4'b0111;
    #1;
    check_eq("forfeit_pre", select_v[3], 0);
    req_valid[0] = 1'b0;
    #1;
    check_eq("forfeit_sel", select_v[3], 2);
    check_eq("forfeit_valid", out_valid[3], 1);
    cycle();

`ifdef XBAR_ARBITER_LOCK_EN
    // Packet lock: source 1 keeps output 0 for three beats despite source 0 pending
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst         = 1'b0;
    out_ready   = '1;
    req_last    = '1;
    req_valid   = 4'b0001;
    req_dest[0] = 2'd0;
    cycle();
    req_valid   = 4'b0011;
    req_dest[1] = 2'd0;
    for (int b = 0; b < 3; b++) begin
      req_last[1] = (b == 2);
      #1;
      check_eq("lock_sel", select_v[0], 1);
      check_eq("lock_rdy", req_ready, 4'b0010);
      cycle();
    end
    #1;
    check_eq("unlock_sel", select_v[0], 0);
    check_eq("unlock_rdy", req_ready, 4'b0001);
    cycle();

    // Lock owner drops: output idles; then reset mid-packet clears the lock
    req_valid   = 4'b0100;
    req_dest[2] = 2'd0;
    req_last[2] = 1'b0;
    cycle();
    req_valid = 4'b0001;
    #1;
    check_eq("lock_hold", out_valid[0], 0);
    cycle();
    rst = 1'b1;
    cycle();
    rst       = 1'b0;
    req_valid = 4'b0101;
    #1;
    check_eq("rst_lock_sel", select_v[0], 0);
    check_eq("rst_lock_rdy", req_ready, 4'b0001);
    cycle();
    req_last = '1;
`endif

    // Randomized traffic: requests held until accepted
    rst       = 1'b1;
    req_valid = '0;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pend[i] = 1'b0;
      wcnt[i] = 0;
    end
    for (int o = 0; o < NO; o++) begin
      hs_cnt[o]  = 0;
      acc_out[o] = 0;
    end
    repeat (10000) begin
      for (int i = 0; i < NI; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]     = 1'b1;
          req_dest[i] = 2'($urandom_range(0, NO - 1));
          wcnt[i]     = 0;
        end
        req_valid[i] = pend[i];
        pend_v[i]    = pend[i];
      end
      out_ready = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      #1;
      rdy_s = req_ready;
      hs_s  = out_valid & out_ready;
      check_eq("dup_beat", rdy_s & ~pend_v, 0);
      cycle();
      for (int o = 0; o < NO; o++) hs_cnt[o] += int'(hs_s[o]);
      for (int i = 0; i < NI; i++) begin
        if (pend[i] && rdy_s[i]) begin
          check_eq("starve", wcnt[i] <= NI - 1, 1);
          acc_out[req_dest[i]]++;
          pend[i] = 1'b0;
        end else if (pend[i] && hs_s[req_dest[i]]) begin
          wcnt[i]++;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (pend[i]) check_eq("starve_end", wcnt[i] <= NI - 1, 1);
    end
    for (int o = 0; o < NO; o++) check_eq("beats_out", hs_cnt[o], acc_out[o]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
